// File: rtl/cache_pkg.sv
// Shared types and default geometry for the way-partitioned L1 tag store.
package cache_pkg;

    localparam int unsigned SETS_DEF    = 1024;
    localparam int unsigned WAYS_DEF    = 4;
    localparam int unsigned TAG_W_DEF   = 20;
    localparam int unsigned DOMAINS_DEF = 4;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_WRITE  = 2'd1,
        OP_INVAL  = 2'd2,
        OP_RSVD   = 2'd3
    } req_op_e;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } tag_state_e;

    // Tag width is fixed here; instances must keep TAG_W equal to TAG_W_DEF.
    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_W_DEF-1:0] tag;
    } cache_tag_entry_t;

endpackage

// File: rtl/dawg_victim_sel.sv
// Victim choice inside a domain partition: lowest allowed invalid way,
// otherwise the first allowed way at or after the round-robin pointer.
module dawg_victim_sel
    import cache_pkg::*;
#(
    parameter int unsigned WAYS = WAYS_DEF
) (
    input  logic [WAYS-1:0]         valid,
    input  logic [WAYS-1:0]         mask,
    input  logic [$clog2(WAYS)-1:0] rr_ptr,
    output logic [$clog2(WAYS)-1:0] victim_way_c,
    output logic                    victim_valid_c
);

    localparam int unsigned WAY_W = $clog2(WAYS);

    logic [WAY_W-1:0] cand;

    always_comb begin
        victim_way_c   = '0;
        victim_valid_c = 1'b0;
        cand           = '0;
        // Walk downwards so the closest way at/after rr_ptr wins.
        for (int k = WAYS - 1; k >= 0; k--) begin
            cand = rr_ptr + WAY_W'(k);
            if (mask[cand]) begin
                victim_way_c = cand;
            end
        end
        if (|mask) begin
            victim_valid_c = 1'b1;
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (mask[WAY_W'(w)] && !valid[WAY_W'(w)]) begin
                victim_way_c   = WAY_W'(w);
                victim_valid_c = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cache_tag_dawg.sv
// Set-associative tag store with per-domain way masks, registered lookup,
// partition-local victim selection and a set-per-cycle reset sweep.
module cache_tag_dawg
    import cache_pkg::*;
#(
    parameter int unsigned SETS    = SETS_DEF,
    parameter int unsigned WAYS    = WAYS_DEF,
    parameter int unsigned TAG_W   = TAG_W_DEF,
    parameter int unsigned DOMAINS = DOMAINS_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [$clog2(SETS)-1:0]    req_index,
    input  logic [TAG_W-1:0]           req_tag,
    input  logic [$clog2(DOMAINS)-1:0] req_domain,
    input  logic [$clog2(WAYS)-1:0]    req_way,
    input  logic                       req_dirty,
    output logic                       rsp_valid,
    output logic                       rsp_hit,
    output logic [$clog2(WAYS)-1:0]    rsp_way,
    output logic                       rsp_dirty,
    output logic [$clog2(WAYS)-1:0]    rsp_victim_way,
    output logic                       rsp_victim_valid,
    output logic                       rsp_victim_dirty,
    output logic [TAG_W-1:0]           rsp_victim_tag,
    output logic                       rsp_err,
    input  logic                       cfg_we,
    input  logic [$clog2(DOMAINS)-1:0] cfg_domain,
    input  logic [WAYS-1:0]            cfg_mask,
    output logic                       init_done
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned WAY_W = $clog2(WAYS);
    localparam int unsigned DOM_W = $clog2(DOMAINS);

    tag_state_e       state_q;
    tag_state_e       state_d;
    logic [IDX_W-1:0] sweep_ptr;
    logic             ready_q;
    logic             sweep_en;
    logic             accept;

    cache_tag_entry_t tag_mem  [SETS][WAYS];
    logic [WAY_W-1:0] rr_mem   [SETS];
    logic [WAYS-1:0]  mask_mem [DOMAINS];

    cache_tag_entry_t set_ent  [WAYS];
    logic [WAYS-1:0]  mask_cur;
    logic [WAYS-1:0]  valid_vec;
    logic [WAYS-1:0]  hit_vec;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim_way;
    logic             victim_valid;
    req_op_e          op;
    logic             way_allowed;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: sweep ends after the last set is cleared
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  if (sweep_ptr == IDX_W'(SETS - 1)) state_d = ST_READY;
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_INIT;
        endcase
    end

    // State-decoded controls
    always_comb begin
        sweep_en = 1'b0;
        accept   = 1'b0;
        case (state_q)
            ST_INIT:  sweep_en = ~rst;
            ST_READY: accept   = req_valid & ready_q & ~rst;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q   <= 1'b0;
            sweep_ptr <= '0;
        end else begin
            ready_q <= (state_d == ST_READY);
            if (sweep_en) begin
                sweep_ptr <= sweep_ptr + IDX_W'(1);
            end
        end
    end

    assign req_ready = ready_q;
    assign init_done = ready_q;

    // Way masks; a write is seen by requests accepted on the following cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < DOMAINS; d++) begin
                mask_mem[DOM_W'(d)] <= '1;
            end
        end else if (cfg_we) begin
            mask_mem[cfg_domain] <= cfg_mask;
        end
    end

    // Combinational read of the addressed set restricted to the domain's ways
    always_comb begin
        mask_cur    = mask_mem[req_domain];
        op          = req_op_e'(req_op);
        way_allowed = mask_cur[req_way];
        hit         = 1'b0;
        hit_way     = '0;
        for (int w = 0; w < WAYS; w++) begin
            set_ent[WAY_W'(w)]   = tag_mem[req_index][WAY_W'(w)];
            valid_vec[WAY_W'(w)] = set_ent[WAY_W'(w)].valid;
            hit_vec[WAY_W'(w)]   = mask_cur[WAY_W'(w)] & set_ent[WAY_W'(w)].valid
                                 & (set_ent[WAY_W'(w)].tag == req_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[WAY_W'(w)]) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    dawg_victim_sel #(
        .WAYS (WAYS)
    ) u_victim_sel (
        .valid          (valid_vec),
        .mask           (mask_cur),
        .rr_ptr         (rr_mem[req_index]),
        .victim_way_c   (victim_way),
        .victim_valid_c (victim_valid)
    );

    // Array and round-robin updates at the accepting edge
    always_ff @(posedge clk) begin
        if (sweep_en) begin
            for (int w = 0; w < WAYS; w++) begin
                tag_mem[sweep_ptr][WAY_W'(w)] <= '0;
            end
            rr_mem[sweep_ptr] <= '0;
        end else if (accept) begin
            case (op)
                OP_LOOKUP: begin
                    if (!hit && victim_valid) begin
                        rr_mem[req_index] <= victim_way + WAY_W'(1);
                    end
                end
                OP_WRITE: begin
                    if (way_allowed) begin
                        tag_mem[req_index][req_way] <= {1'b1, req_dirty, req_tag};
                    end
                end
                default: begin
                    if (way_allowed) begin
                        tag_mem[req_index][req_way].valid <= 1'b0;
                        tag_mem[req_index][req_way].dirty <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Response registers; lookup fields hold between lookups
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid        <= 1'b0;
            rsp_err          <= 1'b0;
            rsp_hit          <= 1'b0;
            rsp_way          <= '0;
            rsp_dirty        <= 1'b0;
            rsp_victim_way   <= '0;
            rsp_victim_valid <= 1'b0;
            rsp_victim_dirty <= 1'b0;
            rsp_victim_tag   <= '0;
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept && (op != OP_LOOKUP) && !way_allowed;
            if (accept && (op == OP_LOOKUP)) begin
                rsp_hit          <= hit;
                rsp_way          <= hit_way;
                rsp_dirty        <= hit & set_ent[hit_way].dirty;
                rsp_victim_way   <= victim_way;
                rsp_victim_valid <= victim_valid;
                rsp_victim_dirty <= victim_valid & set_ent[victim_way].dirty;
                rsp_victim_tag   <= victim_valid ? set_ent[victim_way].tag : '0;
            end
        end
    end

endmodule

// File: tb/tb_cache_tag_dawg.sv
// Randomised and directed checks of cache_tag_dawg against an array-based model.
module tb_cache_tag_dawg;

    localparam int SETS    = 16;
    localparam int WAYS    = 4;
    localparam int TAG_W   = 20;
    localparam int DOMAINS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [3:0]       req_index;
    logic [TAG_W-1:0] req_tag;
    logic [1:0]       req_domain;
    logic [1:0]       req_way;
    logic             req_dirty;
    logic             rsp_valid;
    logic             rsp_hit;
    logic [1:0]       rsp_way;
    logic             rsp_dirty;
    logic [1:0]       rsp_victim_way;
    logic             rsp_victim_valid;
    logic             rsp_victim_dirty;
    logic [TAG_W-1:0] rsp_victim_tag;
    logic             rsp_err;
    logic             cfg_we;
    logic [1:0]       cfg_domain;
    logic [3:0]       cfg_mask;
    logic             init_done;

    cache_tag_dawg #(
        .SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .DOMAINS(DOMAINS)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_index(req_index), .req_tag(req_tag), .req_domain(req_domain),
        .req_way(req_way), .req_dirty(req_dirty),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_dirty(rsp_dirty),
        .rsp_victim_way(rsp_victim_way), .rsp_victim_valid(rsp_victim_valid),
        .rsp_victim_dirty(rsp_victim_dirty), .rsp_victim_tag(rsp_victim_tag),
        .rsp_err(rsp_err),
        .cfg_we(cfg_we), .cfg_domain(cfg_domain), .cfg_mask(cfg_mask),
        .init_done(init_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit               m_v    [SETS][WAYS];
    bit               m_d    [SETS][WAYS];
    logic [TAG_W-1:0] m_t    [SETS][WAYS];
    int               m_rr   [SETS];
    logic [3:0]       m_mask [DOMAINS];

    // Expected response from the model
    int               e_op, e_way, e_vway;
    bit               e_hit, e_dirty, e_vvalid, e_vdirty, e_err, e_vany;
    logic [TAG_W-1:0] e_vtag;

    // Captured DUT response
    logic             g_valid, g_hit, g_dirty, g_vvalid, g_vdirty, g_err;
    logic [1:0]       g_way, g_vway;
    logic [TAG_W-1:0] g_vtag;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_v[s][w] = 0;
                m_d[s][w] = 0;
                m_t[s][w] = '0;
            end
        end
        for (int d = 0; d < DOMAINS; d++) m_mask[d] = 4'hF;
    endtask

    task automatic model_req(input int op, input int idx, input logic [TAG_W-1:0] tag,
                             input int dom, input int way, input bit dirty);
        int inv;
        int w;
        e_op = op; e_hit = 0; e_way = 0; e_dirty = 0; e_err = 0;
        e_vway = 0; e_vvalid = 0; e_vdirty = 0; e_vtag = '0;
        e_vany = (m_mask[dom] != 4'h0);
        if (op == 0) begin
            for (int k = 0; k < WAYS; k++) begin
                if (!e_hit && m_mask[dom][k] && m_v[idx][k] && m_t[idx][k] == tag) begin
                    e_hit = 1; e_way = k; e_dirty = m_d[idx][k];
                end
            end
            if (!e_hit && e_vany) begin
                inv = -1;
                for (int k = 0; k < WAYS; k++)
                    if (inv < 0 && m_mask[dom][k] && !m_v[idx][k]) inv = k;
                if (inv >= 0) begin
                    e_vway = inv;
                end else begin
                    for (int k = WAYS - 1; k >= 0; k--) begin
                        w = (m_rr[idx] + k) % WAYS;
                        if (m_mask[dom][w]) e_vway = w;
                    end
                    e_vvalid = 1;
                    e_vdirty = m_d[idx][e_vway];
                    e_vtag   = m_t[idx][e_vway];
                    m_rr[idx] = (e_vway + 1) % WAYS;
                end
            end
        end else if (!m_mask[dom][way]) begin
            e_err = 1;
        end else if (op == 1) begin
            m_v[idx][way] = 1; m_d[idx][way] = dirty; m_t[idx][way] = tag;
        end else begin
            m_v[idx][way] = 0; m_d[idx][way] = 0;
        end
    endtask

    // Issue one request at a negedge; response is captured at the next negedge
    task automatic drive(input int op, input int idx, input logic [TAG_W-1:0] tag,
                         input int dom, input int way, input bit dirty);
        req_valid = 1'b1; req_op = 2'(op); req_index = 4'(idx); req_tag = tag;
        req_domain = 2'(dom); req_way = 2'(way); req_dirty = dirty;
        model_req(op, idx, tag, dom, way, dirty);
        @(negedge clk);
        g_valid = rsp_valid; g_hit = rsp_hit; g_way = rsp_way; g_dirty = rsp_dirty;
        g_vway = rsp_victim_way; g_vvalid = rsp_victim_valid;
        g_vdirty = rsp_victim_dirty; g_vtag = rsp_victim_tag; g_err = rsp_err;
        req_valid = 1'b0;
    endtask

    task automatic cfg(input int dom, input logic [3:0] mask);
        cfg_we = 1'b1; cfg_domain = 2'(dom); cfg_mask = mask;
        @(negedge clk);
        cfg_we = 1'b0;
        m_mask[dom] = mask;
    endtask

    task automatic test_reset();
        int k;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({req_ready, init_done, rsp_valid, rsp_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ready/done/valid/err=%b required 0000",
                     {req_ready, init_done, rsp_valid, rsp_err});
        end
        n_checks++;
        if ({rsp_hit, rsp_way, rsp_dirty, rsp_victim_way, rsp_victim_valid,
             rsp_victim_dirty, rsp_victim_tag} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_rsp: response fields not zero (victim_tag=%h)", rsp_victim_tag);
        end
        rst = 1'b0;
        k = 0;
        while (!init_done && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k != SETS || init_done !== 1'b1 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL init_len: got %0d cycles (done=%b ready=%b) required %0d", k,
                     init_done, req_ready, SETS);
        end
        model_reset();
        for (int s = 0; s < SETS; s++) begin
            drive(0, s, 20'($urandom), $urandom_range(0, 3), 0, 0);
            n_checks++;
            if ({g_valid, g_hit, g_vway, g_vvalid} !== 5'b10000) begin
                n_fail++;
                $display("FAIL empty_lookup set %0d: got valid/hit/vway/vvalid=%b required 10000",
                         s, {g_valid, g_hit, g_vway, g_vvalid});
            end
        end
    endtask

    task automatic test_partition();
        cfg(0, 4'b0011);
        cfg(1, 4'b1100);
        drive(1, 5, 20'hABC, 0, 1, 0);
        n_checks++;
        if ({g_valid, g_err} !== 2'b10) begin
            n_fail++;
            $display("FAIL part_write: got valid/err=%b required 10", {g_valid, g_err});
        end
        drive(0, 5, 20'hABC, 0, 0, 0);
        n_checks++;
        if ({g_valid, g_hit, g_way} !== 4'b1101) begin
            n_fail++;
            $display("FAIL part_hit_d0: got valid/hit/way=%b required 1101", {g_valid, g_hit, g_way});
        end
        drive(0, 5, 20'hABC, 1, 0, 0);
        n_checks++;
        if ({g_valid, g_hit, g_vway, g_vvalid} !== 5'b10100) begin
            n_fail++;
            $display("FAIL part_miss_d1: got valid/hit/vway/vvalid=%b required 10100",
                     {g_valid, g_hit, g_vway, g_vvalid});
        end
        // Mask write in the same cycle as a lookup only affects later requests
        cfg_we = 1'b1; cfg_domain = 2'd0; cfg_mask = 4'b0000;
        drive(0, 5, 20'hABC, 0, 0, 0);
        cfg_we = 1'b0; m_mask[0] = 4'b0000;
        n_checks++;
        if ({g_valid, g_hit, g_way} !== 4'b1101) begin
            n_fail++;
            $display("FAIL cfg_same_cycle: got valid/hit/way=%b required 1101", {g_valid, g_hit, g_way});
        end
        drive(0, 5, 20'hABC, 0, 0, 0);
        n_checks++;
        if ({g_valid, g_hit, g_vvalid} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_mask: got valid/hit/vvalid=%b required 100", {g_valid, g_hit, g_vvalid});
        end
        cfg(0, 4'b0011);
    endtask

    task automatic test_err();
        drive(1, 5, 20'h123, 1, 0, 1);
        n_checks++;
        if ({g_valid, g_err} !== 2'b11) begin
            n_fail++;
            $display("FAIL err_write: got valid/err=%b required 11", {g_valid, g_err});
        end
        drive(0, 5, 20'h123, 0, 0, 0);
        n_checks++;
        if ({g_valid, g_hit, g_vway, g_vvalid} !== 5'b10000) begin
            n_fail++;
            $display("FAIL err_unchanged: got valid/hit/vway/vvalid=%b required 10000",
                     {g_valid, g_hit, g_vway, g_vvalid});
        end
        drive(2, 5, 20'h0, 1, 1, 0);
        drive(0, 5, 20'hABC, 0, 0, 0);
        n_checks++;
        if ({g_valid, g_hit, g_way} !== 4'b1101) begin
            n_fail++;
            $display("FAIL err_inval: got valid/hit/way=%b required 1101", {g_valid, g_hit, g_way});
        end
        drive(3, 5, 20'h0, 0, 1, 0);
        n_checks++;
        if ({g_valid, g_err} !== 2'b10) begin
            n_fail++;
            $display("FAIL rsvd_op: got valid/err=%b required 10", {g_valid, g_err});
        end
        drive(0, 5, 20'hABC, 0, 0, 0);
        n_checks++;
        if ({g_valid, g_hit, g_vway, g_vvalid} !== 5'b10000) begin
            n_fail++;
            $display("FAIL rsvd_inval: got valid/hit/vway/vvalid=%b required 10000",
                     {g_valid, g_hit, g_vway, g_vvalid});
        end
    endtask

    task automatic test_rr_fill();
        logic [TAG_W-1:0] t;
        cfg(2, 4'b1111);
        for (int w = 0; w < WAYS; w++) drive(1, 3, 20'h300 + 20'(w), 2, w, w[0]);
        for (int n = 0; n < 5; n++) begin
            drive(0, 3, 20'hFFFFF, 2, 0, 0);
            t = 20'h300 + 20'(n % 4);
            n_checks++;
            if (g_valid !== 1'b1 || g_hit !== 1'b0 || g_vvalid !== 1'b1 || g_vway !== 2'(n % 4)
                || g_vdirty !== 1'((n % 4) & 1) || g_vtag !== t) begin
                n_fail++;
                $display("FAIL rr_victim %0d: got hit=%b way=%0d valid=%b dirty=%b tag=%h required way=%0d tag=%h",
                         n, g_hit, g_vway, g_vvalid, g_vdirty, g_vtag, n % 4, t);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 7, 20'h777, 2, 2, 1);
        drive(0, 7, 20'h777, 2, 0, 0);
        n_checks++;
        if ({g_valid, g_hit, g_way, g_dirty} !== 5'b11101) begin
            n_fail++;
            $display("FAIL b2b_hit: got valid/hit/way/dirty=%b required 11101",
                     {g_valid, g_hit, g_way, g_dirty});
        end
        drive(2, 7, 20'h0, 2, 2, 0);
        drive(0, 7, 20'h777, 2, 0, 0);
        n_checks++;
        if ({g_valid, g_hit} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_inval: got valid/hit=%b required 10", {g_valid, g_hit});
        end
    endtask

    task automatic test_random();
        int op, idx, dom, way, cd;
        bit dirty, do_cfg;
        logic [3:0] cm;
        logic [TAG_W-1:0] tag;
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 3); idx = $urandom_range(0, SETS - 1);
            dom = $urandom_range(0, 3); way = $urandom_range(0, 3);
            dirty = 1'($urandom); tag = 20'h5000 + 20'($urandom_range(0, 3));
            if (op >= 2 && $urandom_range(0, 1) == 0) op = 0;
            do_cfg = ($urandom_range(0, 15) == 0);
            cd = $urandom_range(0, 3); cm = 4'($urandom);
            if (do_cfg) begin
                cfg_we = 1'b1; cfg_domain = 2'(cd); cfg_mask = cm;
            end
            drive(op, idx, tag, dom, way, dirty);
            if (do_cfg) begin
                cfg_we = 1'b0; m_mask[cd] = cm;
            end
            n_checks++;
            if (g_valid !== 1'b1 || g_err !== e_err) begin
                n_fail++;
                $display("FAIL rnd_ctrl %0d: got valid=%b err=%b required 1 %b", n, g_valid, g_err, e_err);
            end
            if (e_op == 0) begin
                n_checks++;
                if (g_hit !== e_hit || (e_hit && (g_way !== 2'(e_way) || g_dirty !== e_dirty))) begin
                    n_fail++;
                    $display("FAIL rnd_hit %0d: got hit=%b way=%0d dirty=%b required %b %0d %b",
                             n, g_hit, g_way, g_dirty, e_hit, e_way, e_dirty);
                end
                if (!e_hit) begin
                    n_checks++;
                    if (g_vvalid !== e_vvalid || (e_vany && g_vway !== 2'(e_vway))
                        || (e_vvalid && (g_vdirty !== e_vdirty || g_vtag !== e_vtag))) begin
                        n_fail++;
                        $display("FAIL rnd_victim %0d: got way=%0d valid=%b dirty=%b tag=%h required %0d %b %b %h",
                                 n, g_vway, g_vvalid, g_vdirty, g_vtag, e_vway, e_vvalid, e_vdirty, e_vtag);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        req_valid = 1'b1; req_op = 2'd0; req_index = 4'd3; req_domain = 2'd2;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, req_ready, init_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_reset: got valid/ready/done=%b required 000", {rsp_valid, req_ready, init_done});
        end
        req_valid = 1'b0;
        rst = 1'b0;
        k = 0;
        while (!init_done && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k != SETS || init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_init_len: got %0d cycles (done=%b) required %0d", k, init_done, SETS);
        end
        model_reset();
        for (int d = 0; d < DOMAINS; d++) begin
            for (int w = 0; w < WAYS; w++) begin
                drive(2, 0, 20'h0, d, w, 0);
                n_checks++;
                if ({g_valid, g_err} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL mask_reset d%0d w%0d: got valid/err=%b required 10", d, w, {g_valid, g_err});
                end
            end
        end
        // One-hot masks expose each way individually as the invalid victim
        for (int d = 0; d < DOMAINS; d++) cfg(d, 4'(1 << d));
        for (int s = 0; s < SETS; s++) begin
            for (int d = 0; d < DOMAINS; d++) begin
                drive(0, s, 20'h5000 + 20'($urandom_range(0, 3)), d, 0, 0);
                n_checks++;
                if ({g_valid, g_hit, g_vvalid} !== 3'b100 || g_vway !== 2'(d)) begin
                    n_fail++;
                    $display("FAIL sweep_clear set %0d way %0d: got valid/hit/vvalid=%b vway=%0d",
                             s, d, {g_valid, g_hit, g_vvalid}, g_vway);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_index = '0; req_tag = '0;
        req_domain = '0; req_way = '0; req_dirty = 1'b0;
        cfg_we = 1'b0; cfg_domain = '0; cfg_mask = '0;
        test_reset();
        test_partition();
        test_err();
        test_rr_fill();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_tag_dawg.md
# cache_tag_dawg

Parametrised set-associative tag store for the partitioned L1, with per-domain way masks (DAWG-style way partitioning). It holds valid/dirty/tag per way, performs a one-cycle registered lookup restricted to the requesting domain's ways, and picks a victim inside that domain's partition. It sits between the cache controller FSM and the data array, replacing the single-port, unpartitioned tag memory. A sequential reset sweep clears the array instead of a single-cycle clear.

## Interface
- SETS, 1024: number of sets, power of two
- WAYS, 4: associativity, power of two, ≥2
- TAG_W, 20: tag width
- DOMAINS, 4: number of security domains, power of two
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_op  in  2  0=LOOKUP, 1=WRITE, 2=INVAL, 3=reserved (treated as INVAL)
- req_index  in  log2(SETS)  set index
- req_tag  in  TAG_W  tag for lookup/write
- req_domain  in  log2(DOMAINS)  requesting domain
- req_way  in  log2(WAYS)  target way for WRITE/INVAL
- req_dirty  in  1  dirty bit for WRITE
- rsp_valid  out  1  response strobe, one cycle
- rsp_hit, rsp_way, rsp_dirty  out  1 / log2(WAYS) / 1  lookup result
- rsp_victim_way, rsp_victim_valid, rsp_victim_dirty, rsp_victim_tag  out  log2(WAYS)/1/1/TAG_W  victim on miss
- rsp_err  out  1  WRITE/INVAL to a way outside the domain mask
- cfg_we, cfg_domain, cfg_mask  in  1 / log2(DOMAINS) / WAYS  way-mask programming
- init_done  out  1  high once reset sweep completes

## Operation
- States: INIT, READY. rst (any state) → INIT, sweep pointer 0. INIT clears all ways of set `ptr` (valid=dirty=0, tag=0) and the set's round-robin pointer, one set per cycle; after set SETS-1 → READY. req_ready=0 in INIT, 1 in READY.
- Way masks reset to all-ones for every domain; cfg_we writes mask at clock edge, honoured in INIT and READY, effective for requests accepted next cycle. cfg_mask=0 is legal: every lookup misses with rsp_victim_valid=0.
- LOOKUP: hit = some way w with mask[w], valid, tag match; lowest such w reported. Ways outside mask never hit, even if matching.
- Miss victim: lowest-index allowed invalid way (rsp_victim_valid=0); else first allowed way at or after set's RR pointer, wrapping (rsp_victim_valid=1, its dirty/tag reported). On a miss with a valid victim, RR pointer ← victim+1 mod WAYS.
- WRITE: if mask[req_way], entry ← {1, req_dirty, req_tag}; else no update, rsp_err=1. INVAL: same check, valid←0, dirty←0.
- Outputs other than rsp_valid/rsp_err hold last value; rsp_hit only meaningful for LOOKUP.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_err=0, init_done=0, all rsp_* fields 0.
- INIT lasts exactly SETS cycles after rst deasserts; init_done and req_ready rise together.
- Every accepted request yields rsp_valid exactly one cycle later; throughput one request/cycle.
- Array updates at the accepting edge; a request accepted the next cycle on the same set sees the new contents (no stale read).
- rst asserted mid-operation: pending response dropped (rsp_valid=0 next cycle), sweep restarts from set 0.

## Structure
- cache_pkg: cache_tag_entry_t {valid, dirty, tag}, req_op_e, default parameters.
- Sub-module dawg_victim_sel: combinational; from valid vector, mask, RR pointer → victim way and valid flag.

## Test plan
- rst 1 cycle, SETS=16 → init_done high 16 cycles later; LOOKUP any set misses, victim_way=0, victim_valid=0.
- Domain 0 mask 0011, domain 1 mask 1100; d0 WRITE set 5 way 1 tag 0xABC → d0 LOOKUP hits way 1; d1 LOOKUP same tag misses, victim way 2.
- d1 WRITE way 0 → rsp_err=1, set unchanged.
- Fill all 4 ways of set 3 with mask 1111, repeated misses → victims 0,1,2,3,0 with correct dirty/tag.
- WRITE set 7 then LOOKUP set 7 back-to-back → hit.
- rst during traffic → rsp_valid 0 next cycle, full sweep, all sets invalid after.
